// File: rtl/aibio_txdll_ctrl_pkg.sv
// Shared types and constants for the TX DLL power-up / lock sequencer.
package aibio_txdll_ctrl_pkg;

  localparam int CAP_W = 5;
  localparam logic [CAP_W-1:0] CAP_MAX = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENABLE    = 3'd1,
    ST_RESET     = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_FAIL      = 3'd5
  } txdll_ctrl_state_e;

  // Cap code plus step, clamped at the top code instead of wrapping.
  function automatic logic [CAP_W-1:0] cap_sat_add(input logic [CAP_W-1:0] cap,
                                                   input logic [2:0] step);
    logic [CAP_W:0] sum;
    sum = {1'b0, cap} + {3'b000, step};
    if (sum > {1'b0, CAP_MAX}) return CAP_MAX;
    return sum[CAP_W-1:0];
  endfunction

endpackage

// File: rtl/aibio_txdll_ctrl_sync.sv
// Two-flop synchronizer for a single asynchronous status level.
module aibio_txdll_ctrl_sync (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic sig_sync
);

  logic meta_p0;

  // Metastability stage followed by the settled stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0  <= 1'b0;
      sig_sync <= 1'b0;
    end else begin
      meta_p0  <= sig;
      sig_sync <= meta_p0;
    end
  end

endmodule

// File: rtl/aibio_txdll_ctrl.sv
// TX DLL bring-up sequencer: settle, reset, lock wait with cap-code retries,
// lock-loss monitoring and ready/fail reporting.
module aibio_txdll_ctrl
  import aibio_txdll_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int LOCK_FILTER   = 4,
  parameter int MAX_RETRY     = 7
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_pwrgood,
  input  logic       i_dll_lock,
  input  logic [4:0] i_cap_init,
  input  logic [2:0] i_cap_step,
  output logic       o_dll_en,
  output logic       o_dll_reset,
  output logic [4:0] o_dll_capctrl,
  output logic       o_ready,
  output logic       o_fail,
  output logic       o_relock,
  output logic [2:0] o_state,
  output logic [2:0] o_retry_cnt
);

  localparam int DW = $clog2(LOCK_TIMEOUT + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam logic [DW-1:0] SETTLE_LD  = DW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] RST_LD     = DW'(RST_CYCLES - 1);
  localparam logic [DW-1:0] TIMEOUT_LD = DW'(LOCK_TIMEOUT - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [FW-1:0] FILT_MAX   = FW'(LOCK_FILTER);
  localparam logic [FW-1:0] FILT_ONE   = FW'(1);
  localparam logic [2:0]    RETRY_MAX  = 3'(MAX_RETRY);

  txdll_ctrl_state_e state, next_state;
  logic [DW-1:0]     dwell, dwell_next;
  logic [CAP_W-1:0]  cap, cap_next;
  logic [2:0]        retry, retry_next;
  logic              relock_set, relock_evt;
  logic              lock_s;
  logic              filt_lvl;
  logic [FW-1:0]     filt_cnt, filt_run;
  logic              qual_hi, qual_lo, entry;
  logic              en_d, rst_d, ready_d, fail_d;

  aibio_txdll_ctrl_sync u_lock_sync (
    .clk      (i_clk),
    .reset    (i_reset),
    .sig      (i_dll_lock),
    .sig_sync (lock_s)
  );

  assign entry = (next_state != state);

  // Run length of the current lock_s level including this sample; a level
  // change restarts the run at one, saturating at the filter length.
  always_comb begin
    filt_run = FILT_ONE;
    if (lock_s == filt_lvl)
      filt_run = (filt_cnt == FILT_MAX) ? FILT_MAX : filt_cnt + FILT_ONE;
  end

  assign qual_hi = lock_s  && (filt_run == FILT_MAX);
  assign qual_lo = !lock_s && (filt_run == FILT_MAX);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Next-state, cap-code and retry decisions; abort overrides everything.
  always_comb begin
    next_state = state;
    cap_next   = cap;
    retry_next = retry;
    relock_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && i_pwrgood) begin
          next_state = ST_ENABLE;
          cap_next   = i_cap_init;
          retry_next = 3'd0;
        end
      end
      ST_ENABLE:    if (dwell == '0) next_state = ST_RESET;
      ST_RESET:     if (dwell == '0) next_state = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (qual_hi) begin
          next_state = ST_LOCKED;
        end else if (dwell == '0) begin
          if (retry == RETRY_MAX) begin
            next_state = ST_FAIL;
          end else begin
            next_state = ST_RESET;
            cap_next   = cap_sat_add(cap, i_cap_step);
            retry_next = retry + 3'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (qual_lo) begin
          next_state = ST_RESET;
          retry_next = 3'd0;
          relock_set = 1'b1;
        end
      end
      ST_FAIL:      next_state = ST_FAIL;
      default:      next_state = ST_IDLE;
    endcase
    if ((state != ST_IDLE) && (!i_start || !i_pwrgood)) begin
      next_state = ST_IDLE;
      cap_next   = cap;
      retry_next = retry;
      relock_set = 1'b0;
    end
  end

  // Dwell down-counter, reloaded with the new state's budget on every entry.
  always_comb begin
    dwell_next = dwell;
    if (entry) begin
      case (next_state)
        ST_ENABLE:    dwell_next = SETTLE_LD;
        ST_RESET:     dwell_next = RST_LD;
        ST_WAIT_LOCK: dwell_next = TIMEOUT_LD;
        default:      dwell_next = '0;
      endcase
    end else if (dwell != '0) begin
      dwell_next = dwell - DWELL_ONE;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    en_d    = 1'b0;
    rst_d   = 1'b1;
    ready_d = 1'b0;
    fail_d  = 1'b0;
    case (state)
      ST_ENABLE, ST_RESET: en_d = 1'b1;
      ST_WAIT_LOCK: begin
        en_d  = 1'b1;
        rst_d = 1'b0;
      end
      ST_LOCKED: begin
        en_d    = 1'b1;
        rst_d   = 1'b0;
        ready_d = 1'b1;
      end
      ST_FAIL:  fail_d = 1'b1;
      default:  ;
    endcase
  end

  // Counters, cap code, retry count and lock filter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      dwell      <= '0;
      cap        <= '0;
      retry      <= 3'd0;
      relock_evt <= 1'b0;
      filt_lvl   <= 1'b0;
      filt_cnt   <= '0;
    end else begin
      dwell      <= dwell_next;
      cap        <= cap_next;
      retry      <= retry_next;
      relock_evt <= relock_set;
      filt_lvl   <= lock_s;
      filt_cnt   <= entry ? '0 : filt_run;
    end
  end

  // Registered outputs; relock is delayed to line up with ready dropping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_dll_en    <= 1'b0;
      o_dll_reset <= 1'b1;
      o_ready     <= 1'b0;
      o_fail      <= 1'b0;
      o_relock    <= 1'b0;
      o_state     <= 3'd0;
    end else begin
      o_dll_en    <= en_d;
      o_dll_reset <= rst_d;
      o_ready     <= ready_d;
      o_fail      <= fail_d;
      o_relock    <= relock_evt;
      o_state     <= state;
    end
  end

  assign o_dll_capctrl = cap;
  assign o_retry_cnt   = retry;

endmodule

// File: tb/tb_aibio_txdll_ctrl.sv
// Bench for the TX DLL sequencer: table of bring-up scenarios plus directed
// sequences for timing, glitch/loss, abort, reset and lock/timeout collisions.
module tb_aibio_txdll_ctrl;

  logic       clk = 1'b0;
  logic       i_reset, i_start, i_pwrgood, i_dll_lock;
  logic [4:0] i_cap_init;
  logic [2:0] i_cap_step;
  logic       o_dll_en, o_dll_reset, o_ready, o_fail, o_relock;
  logic [4:0] o_dll_capctrl;
  logic [2:0] o_state, o_retry_cnt;

  int total  = 0;
  int passed = 0;

  aibio_txdll_ctrl #(
    .SETTLE_CYCLES(16), .RST_CYCLES(8), .LOCK_TIMEOUT(32),
    .LOCK_FILTER(4), .MAX_RETRY(7)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_pwrgood(i_pwrgood),
    .i_dll_lock(i_dll_lock), .i_cap_init(i_cap_init), .i_cap_step(i_cap_step),
    .o_dll_en(o_dll_en), .o_dll_reset(o_dll_reset), .o_dll_capctrl(o_dll_capctrl),
    .o_ready(o_ready), .o_fail(o_fail), .o_relock(o_relock),
    .o_state(o_state), .o_retry_cnt(o_retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] cap_init;
    logic [2:0] cap_step;
    int         n_timeouts;  // 8 means lock is never given
    int         exp_cap;
    int         exp_retry;
    bit         exp_ready;
    bit         exp_fail;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_start = 1'b0; i_pwrgood = 1'b0; i_dll_lock = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    tick();
  endtask

  // kind 0: o_state==a && o_retry_cnt==b; kind 1: o_ready==a; kind 2: o_fail==a
  task automatic wait_for(input int kind, input int a, input int b,
                          input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      if ((kind == 0 && int'(o_state) == a && int'(o_retry_cnt) == b) ||
          (kind == 1 && int'(o_ready) == a) ||
          (kind == 2 && int'(o_fail) == a)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Lock arrives a given number of cycles after WAIT_LOCK is first visible.
  task automatic collision_case(input int delay, input int exp_retry, input string name);
    bit ok;
    do_reset();
    i_cap_init = 5'd10; i_cap_step = 3'd3; i_start = 1'b1; i_pwrgood = 1'b1;
    wait_for(0, 3, 0, 200, ok);
    check({name, "_wait_reached"}, int'(ok), 1);
    for (int k = 0; k < delay; k++) tick();
    i_dll_lock = 1'b1;
    wait_for(1, 1, 0, 200, ok);
    check({name, "_ready"}, int'(ok), 1);
    check({name, "_retry"}, int'(o_retry_cnt), exp_retry);
  endtask

  initial begin
    bit ok;
    int cnt, pulses, ready_low, st_at_pulse, ready_at_pulse;

    vecs[0] = '{5'd10, 3'd3, 0, 10, 0, 1'b1, 1'b0};
    vecs[1] = '{5'd10, 3'd3, 2, 16, 2, 1'b1, 1'b0};
    vecs[2] = '{5'd0,  3'd5, 1, 5,  1, 1'b1, 1'b0};
    vecs[3] = '{5'd30, 3'd1, 3, 31, 3, 1'b1, 1'b0};
    vecs[4] = '{5'd31, 3'd0, 7, 31, 7, 1'b1, 1'b0};
    vecs[5] = '{5'd28, 3'd7, 8, 31, 7, 1'b0, 1'b1};

    i_cap_init = 5'd0; i_cap_step = 3'd0;
    i_reset = 1'b1; i_start = 1'b0; i_pwrgood = 1'b0; i_dll_lock = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_en",     int'(o_dll_en), 0);
    check("rst_dllrst", int'(o_dll_reset), 1);
    check("rst_cap",    int'(o_dll_capctrl), 0);
    check("rst_ready",  int'(o_ready), 0);
    check("rst_fail",   int'(o_fail), 0);
    check("rst_relock", int'(o_relock), 0);
    check("rst_state",  int'(o_state), 0);
    check("rst_retry",  int'(o_retry_cnt), 0);

    // Nominal bring-up timing
    do_reset();
    i_cap_init = 5'd10; i_cap_step = 3'd3; i_start = 1'b1; i_pwrgood = 1'b1;
    tick();  // IDLE -> ENABLE edge
    check("nom_en_lags", int'(o_dll_en), 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      cnt++;
      if (cnt == 1) check("nom_en_rise", int'(o_dll_en), 1);
      if (!o_dll_reset) break;
    end
    check("nom_dllrst_fall_cycle", cnt, 25);
    for (int k = 0; k < 5; k++) tick();
    i_dll_lock = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20 && !o_ready; c++) begin
      tick();
      cnt++;
    end
    check("nom_ready_latency_le7", int'(o_ready && cnt >= 1 && cnt <= 7), 1);
    check("nom_cap", int'(o_dll_capctrl), 10);
    check("nom_retry", int'(o_retry_cnt), 0);

    // Short glitch on lock must not trigger relock
    i_dll_lock = 1'b0;
    tick(); tick();
    i_dll_lock = 1'b1;
    pulses = 0; ready_low = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (o_relock) pulses++;
      if (!o_ready) ready_low++;
    end
    check("glitch_no_relock", pulses, 0);
    check("glitch_ready_held", ready_low, 0);

    // Real loss: six low cycles, one relock pulse, recovery with cap kept
    i_dll_lock = 1'b0;
    pulses = 0; st_at_pulse = -1; ready_at_pulse = -1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (c == 6) i_dll_lock = 1'b1;
      if (o_relock) begin
        pulses++;
        st_at_pulse = int'(o_state);
        ready_at_pulse = int'(o_ready);
      end
    end
    check("loss_relock_pulses", pulses, 1);
    check("loss_state_at_pulse", st_at_pulse, 2);
    check("loss_ready_at_pulse", ready_at_pulse, 0);
    check("loss_relocked", int'(o_ready), 1);
    check("loss_cap_kept", int'(o_dll_capctrl), 10);
    check("loss_retry", int'(o_retry_cnt), 0);

    // Table of bring-up scenarios; the last row exhausts retries into FAIL
    for (int i = 0; i < 6; i++) begin
      do_reset();
      i_cap_init = vecs[i].cap_init; i_cap_step = vecs[i].cap_step;
      i_start = 1'b1; i_pwrgood = 1'b1;
      if (vecs[i].n_timeouts < 8) begin
        wait_for(0, 3, vecs[i].n_timeouts, 3000, ok);
        check($sformatf("vec%0d_wait_reached", i), int'(ok), 1);
        i_dll_lock = 1'b1;
        wait_for(1, 1, 0, 200, ok);
      end else begin
        wait_for(2, 1, 0, 3000, ok);
      end
      check($sformatf("vec%0d_done", i), int'(ok), 1);
      tick(); tick();
      check($sformatf("vec%0d_cap", i),    int'(o_dll_capctrl), vecs[i].exp_cap);
      check($sformatf("vec%0d_retry", i),  int'(o_retry_cnt), vecs[i].exp_retry);
      check($sformatf("vec%0d_ready", i),  int'(o_ready), int'(vecs[i].exp_ready));
      check($sformatf("vec%0d_fail", i),   int'(o_fail), int'(vecs[i].exp_fail));
      check($sformatf("vec%0d_en", i),     int'(o_dll_en), int'(vecs[i].exp_ready));
      check($sformatf("vec%0d_dllrst", i), int'(o_dll_reset), int'(!vecs[i].exp_ready));
    end

    // FAIL holds while start is high, exits to IDLE once start drops
    for (int k = 0; k < 10; k++) tick();
    check("fail_held", int'(o_fail), 1);
    check("fail_state", int'(o_state), 5);
    i_start = 1'b0;
    tick(); tick();
    check("fail_exit_state", int'(o_state), 0);
    check("fail_exit_flag", int'(o_fail), 0);

    // Power-good drop during WAIT_LOCK aborts to IDLE
    do_reset();
    i_cap_init = 5'd10; i_cap_step = 3'd3; i_start = 1'b1; i_pwrgood = 1'b1;
    wait_for(0, 3, 0, 200, ok);
    check("abort_wait_reached", int'(ok), 1);
    i_pwrgood = 1'b0;
    tick(); tick();
    check("abort_state", int'(o_state), 0);
    check("abort_en", int'(o_dll_en), 0);
    check("abort_dllrst", int'(o_dll_reset), 1);

    // Synchronous reset while LOCKED
    i_pwrgood = 1'b1;
    wait_for(0, 3, 0, 200, ok);
    check("rstlk_wait_reached", int'(ok), 1);
    i_dll_lock = 1'b1;
    wait_for(1, 1, 0, 200, ok);
    check("rstlk_locked", int'(ok), 1);
    i_reset = 1'b1;
    tick();
    check("rstlk_en",     int'(o_dll_en), 0);
    check("rstlk_dllrst", int'(o_dll_reset), 1);
    check("rstlk_cap",    int'(o_dll_capctrl), 0);
    check("rstlk_ready",  int'(o_ready), 0);
    check("rstlk_state",  int'(o_state), 0);
    check("rstlk_retry",  int'(o_retry_cnt), 0);
    i_reset = 1'b0;

    // Qualified lock coinciding with timeout wins; one cycle later loses
    collision_case(25, 0, "coll_same");
    collision_case(26, 1, "coll_late");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
